ex_muldiv_seq: RTL
==================

Name: ex_muldiv_seq

Overview:
- Iterative multiply/divide sequencer attached to the EX stage, beside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU issued from EX and runs a 32-iteration shift-add / restoring-subtract datapath.
- Holds the pipeline with a stall request while busy, then commits the result to architectural HI/LO.
- Also services MTHI/MTLO writes; HI/LO are always readable for MFHI/MFLO.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.
- ITER, 32, CALC iterations; must equal XLEN.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  EX holds a mult/div instruction
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start
- opa  in  32  rs value (multiplicand / dividend)
- opb  in  32  rt value (multiplier / divisor)
- flush  in  1  kill in-flight operation (branch/exception flush)
- wr_hi  in  1  MTHI write enable
- wr_lo  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- stall  out  1  freeze IF/ID/EX; combinational
- busy  out  1  state is CALC or FIX
- done  out  1  one-cycle pulse, HI/LO just committed
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi=0, lo=0, done=0, busy=0.
  - Iteration counter and working registers cleared.
- States:
  - IDLE: start & ~flush captures op, |opa|, |opb| and the sign flags (signed ops only), loads counter=ITER-1, goes to CALC.
  - CALC: one iteration per cycle, counter decrements; at counter==0 goes to FIX.
  - FIX: applies sign correction, writes hi/lo, goes to DONE.
  - DONE: done=1 for this cycle only, then IDLE unconditionally. start in DONE is ignored; EX re-presents it the following cycle.
- Latency: start accepted at edge N (state IDLE->CALC), DONE entered at edge N+33, done high during cycle N+33. Latency is fixed and independent of operand values.
- stall = (state==IDLE & start & ~flush) | busy. Stall is deasserted in DONE so the instruction leaves EX that cycle.
- Multiply: 64-bit product of magnitudes; signed MULT negates the 64-bit product when sign(opa)^sign(opb). Result: hi=prod[63:32], lo=prod[31:0].
- Divide: restoring divide on magnitudes.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Result: lo=quotient, hi=remainder.
  - opb==0 (any divide): lo=32'hFFFFFFFF, hi=opa. Same latency, no exception.
  - Signed 0x80000000 / -1: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - wr_hi/wr_lo update hi/lo at the edge only when state is IDLE or DONE and start is low.
  - If wr_* and start are high in the same IDLE cycle, start wins and the write is dropped.
  - wr_* while busy is ignored; EX is stalled, so this cannot occur legally.
- Flush:
  - In CALC or FIX, returns to IDLE next edge; hi/lo unchanged, no done pulse.
  - In IDLE, flush blocks acceptance of start.
  - In DONE, flush has no effect; the commit already happened.
- Reset asserted mid-operation aborts immediately; hi=lo=0.
- hi/lo change only at FIX->DONE, on a legal wr_*, or on reset.

Test Plan:
- Reset, then MULTU opa=0xFFFFFFFF opb=0xFFFFFFFF -> stall high 33 cycles; done at +33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT opa=-3 (0xFFFFFFFD) opb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV opa=-7 opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU opa=100 opb=0 -> lo=0xFFFFFFFF, hi=100, done at +33; signed DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via wr_hi/wr_lo; start DIVU 10/3; flush at cycle +10 -> IDLE next edge, no done, hi=0x11, lo=0x22, stall low.
- start and wr_lo=1 (wdata=0x55) in the same IDLE cycle -> write dropped; after DIVU 9/2 completes, lo=4, hi=1.
- Drive reset low asynchronously (between clk edges) at cycle +20 of a MULT -> busy/stall/hi/lo go 0 immediately; after release, a new MULTU 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU.
// Owns architectural HI/LO; stalls the pipeline for the fixed 33-cycle calculation.
module ex_muldiv_seq #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic            flush,
   input  logic            wr_hi,
   input  logic            wr_lo,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(ITER);
   localparam int unsigned PROD_W = 2 * XLEN;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_accept;
   logic                w_commit;
   logic                w_wr_ok;

   logic [CNT_W-1:0]    r_cnt;
   logic                r_is_div;
   logic                r_neg_q;
   logic                r_neg_a;
   logic                r_bzero;
   logic [XLEN-1:0]     r_wh;
   logic [XLEN-1:0]     r_wl;
   logic [XLEN-1:0]     r_mb;
   logic [XLEN-1:0]     r_hi;
   logic [XLEN-1:0]     r_lo;

   logic                w_signed_op;
   logic                w_sa;
   logic                w_sb;
   logic [XLEN-1:0]     w_abs_a;
   logic [XLEN-1:0]     w_abs_b;

   logic [XLEN:0]       w_mul_sum;
   logic [XLEN:0]       w_div_sh;
   logic                w_div_ge;
   logic [XLEN-1:0]     w_div_diff;
   logic [XLEN-1:0]     w_iter_wh;
   logic [XLEN-1:0]     w_iter_wl;

   logic [PROD_W-1:0]   w_prod;
   logic [PROD_W-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_fix_hi;
   logic [XLEN-1:0]     w_fix_lo;

   // op[1] selects divide, op[0] selects the unsigned variant
   assign w_signed_op = ~op[0];
   assign w_sa        = w_signed_op & opa[XLEN-1];
   assign w_sb        = w_signed_op & opb[XLEN-1];
   assign w_abs_a     = w_sa ? (XLEN'(0) - opa) : opa;
   assign w_abs_b     = w_sb ? (XLEN'(0) - opb) : opb;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !flush) begin
               w_next_state = S_CALC;
               w_accept     = 1'b1;
            end
         end
         S_CALC: begin
            if (flush) begin
               w_next_state = S_IDLE;
            end else if (r_cnt == CNT_W'(0)) begin
               w_next_state = S_FIX;
            end
         end
         S_FIX: begin
            if (flush) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign w_commit = (r_state == S_FIX) && !flush;
   assign w_wr_ok  = ((r_state == S_IDLE) || (r_state == S_DONE)) && !start;

   // One shift-add (multiply) or restoring-subtract (divide) step on {r_wh, r_wl}
   assign w_mul_sum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_mb} : (XLEN+1)'(0));
   assign w_div_sh   = {r_wh, r_wl[XLEN-1]};
   assign w_div_ge   = w_div_sh >= {1'b0, r_mb};
   assign w_div_diff = w_div_sh[XLEN-1:0] - r_mb;
   assign w_iter_wh  = r_is_div ? (w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0])
                                : w_mul_sum[XLEN:1];
   assign w_iter_wl  = r_is_div ? {r_wl[XLEN-2:0], w_div_ge}
                                : {w_mul_sum[0], r_wl[XLEN-1:1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_a  <= 1'b0;
         r_bzero  <= 1'b0;
         r_wh     <= '0;
         r_wl     <= '0;
         r_mb     <= '0;
      end else if (w_accept) begin
         r_cnt    <= CNT_W'(ITER - 1);
         r_is_div <= op[1];
         r_neg_q  <= w_sa ^ w_sb;
         r_neg_a  <= w_sa;
         r_bzero  <= (opb == XLEN'(0));
         r_wh     <= '0;
         r_wl     <= w_abs_a;
         r_mb     <= w_abs_b;
      end else if (r_state == S_CALC) begin
         r_cnt    <= r_cnt - CNT_W'(1);
         r_wh     <= w_iter_wh;
         r_wl     <= w_iter_wl;
      end
   end

   // Sign fix-up; divide-by-zero leaves |opa| in the remainder, which re-signs back to opa
   assign w_prod     = {r_wh, r_wl};
   assign w_prod_fix = r_neg_q ? (PROD_W'(0) - w_prod) : w_prod;
   assign w_quo      = r_bzero ? {XLEN{1'b1}} : (r_neg_q ? (XLEN'(0) - r_wl) : r_wl);
   assign w_rem      = r_neg_a ? (XLEN'(0) - r_wh) : r_wh;
   assign w_fix_hi   = r_is_div ? w_rem : w_prod_fix[PROD_W-1:XLEN];
   assign w_fix_lo   = r_is_div ? w_quo : w_prod_fix[XLEN-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         r_hi <= w_fix_hi;
         r_lo <= w_fix_lo;
      end else if (w_wr_ok) begin
         if (wr_hi) begin
            r_hi <= wdata;
         end
         if (wr_lo) begin
            r_lo <= wdata;
         end
      end
   end

   assign busy  = (r_state == S_CALC) || (r_state == S_FIX);
   assign stall = ((r_state == S_IDLE) && start && !flush) || busy;
   assign done  = (r_state == S_DONE);
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule
